// File: rtl/udp_eth_tx_mux.sv
// Packet-granular round-robin arbiter merging N UDP TX channels (metadata beat + data stream)
// onto one downstream UDP TX port, with per-channel enable mask and sent-packet counters.
module udp_eth_tx_mux #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DATA_WIDTH     = 256,
    parameter int unsigned KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned IP_ADDR_WIDTH  = 32,
    parameter int unsigned UDP_PORT_WIDTH = 16,
    parameter int unsigned UDP_LEN_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_CH-1:0]                  ch_enable,
    input  logic [NUM_CH-1:0]                  s_udp_meta_valid,
    output logic [NUM_CH-1:0]                  s_udp_meta_ready,
    input  logic [NUM_CH*IP_ADDR_WIDTH-1:0]    s_udp_meta_ip_addr,
    input  logic [NUM_CH*UDP_PORT_WIDTH-1:0]   s_udp_meta_dst_port,
    input  logic [NUM_CH*UDP_PORT_WIDTH-1:0]   s_udp_meta_src_port,
    input  logic [NUM_CH*UDP_LEN_WIDTH-1:0]    s_udp_meta_data_len,
    input  logic [NUM_CH-1:0]                  s_data_stream_tvalid,
    output logic [NUM_CH-1:0]                  s_data_stream_tready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]       s_data_stream_tdata,
    input  logic [NUM_CH*KEEP_WIDTH-1:0]       s_data_stream_tkeep,
    input  logic [NUM_CH-1:0]                  s_data_stream_tfirst,
    input  logic [NUM_CH-1:0]                  s_data_stream_tlast,
    output logic                               m_udp_meta_valid,
    input  logic                               m_udp_meta_ready,
    output logic [IP_ADDR_WIDTH-1:0]           m_udp_meta_ip_addr,
    output logic [UDP_PORT_WIDTH-1:0]          m_udp_meta_dst_port,
    output logic [UDP_PORT_WIDTH-1:0]          m_udp_meta_src_port,
    output logic [UDP_LEN_WIDTH-1:0]           m_udp_meta_data_len,
    output logic                               m_data_stream_tvalid,
    input  logic                               m_data_stream_tready,
    output logic [DATA_WIDTH-1:0]              m_data_stream_tdata,
    output logic [KEEP_WIDTH-1:0]              m_data_stream_tkeep,
    output logic                               m_data_stream_tfirst,
    output logic                               m_data_stream_tlast,
    output logic [$clog2(NUM_CH)-1:0]          grant_ch,
    output logic                               busy,
    output logic [NUM_CH*CNT_WIDTH-1:0]        pkt_cnt
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, META, DATA} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d, grant_d, arb_ch, idx;
    logic [NUM_CH-1:0] req;
    logic              found;
    logic              pkt_done;
    logic              rst_meta_n, rst_sync_n;

    // Asynchronous assertion, deassertion re-timed to clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_n <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta_n <= 1'b1;
            rst_sync_n <= rst_meta_n;
        end
    end

    // Round-robin search starting just after the last channel served
    always_comb begin
        req    = ch_enable & s_udp_meta_valid;
        found  = 1'b0;
        arb_ch = '0;
        idx    = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = CH_W'((32'(rr_ptr_q) + i) % NUM_CH);
            if (!found && req[idx]) begin
                found  = 1'b1;
                arb_ch = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_ch;
        rr_ptr_d = rr_ptr_q;
        pkt_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = arb_ch;
                    state_d = META;
                end
            end
            META: begin
                if (m_udp_meta_valid && m_udp_meta_ready) state_d = DATA;
            end
            DATA: begin
                if (m_data_stream_tvalid && m_data_stream_tready && m_data_stream_tlast) begin
                    pkt_done = 1'b1;
                    rr_ptr_d = grant_ch;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q  <= IDLE;
            grant_ch <= '0;
            rr_ptr_q <= CH_W'(NUM_CH - 1);
            pkt_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            grant_ch <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            if (pkt_done) begin
                pkt_cnt[grant_ch*CNT_WIDTH +: CNT_WIDTH] <=
                    pkt_cnt[grant_ch*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
            end
        end
    end

    // Pass-through of the granted channel; everything else held at zero
    always_comb begin
        s_udp_meta_ready     = '0;
        s_data_stream_tready = '0;
        m_udp_meta_valid     = 1'b0;
        m_udp_meta_ip_addr   = '0;
        m_udp_meta_dst_port  = '0;
        m_udp_meta_src_port  = '0;
        m_udp_meta_data_len  = '0;
        m_data_stream_tvalid = 1'b0;
        m_data_stream_tdata  = '0;
        m_data_stream_tkeep  = '0;
        m_data_stream_tfirst = 1'b0;
        m_data_stream_tlast  = 1'b0;
        case (state_q)
            META: begin
                m_udp_meta_valid           = s_udp_meta_valid[grant_ch];
                s_udp_meta_ready[grant_ch] = m_udp_meta_ready;
                m_udp_meta_ip_addr  = s_udp_meta_ip_addr[grant_ch*IP_ADDR_WIDTH +: IP_ADDR_WIDTH];
                m_udp_meta_dst_port = s_udp_meta_dst_port[grant_ch*UDP_PORT_WIDTH +: UDP_PORT_WIDTH];
                m_udp_meta_src_port = s_udp_meta_src_port[grant_ch*UDP_PORT_WIDTH +: UDP_PORT_WIDTH];
                m_udp_meta_data_len = s_udp_meta_data_len[grant_ch*UDP_LEN_WIDTH +: UDP_LEN_WIDTH];
            end
            DATA: begin
                m_data_stream_tvalid           = s_data_stream_tvalid[grant_ch];
                s_data_stream_tready[grant_ch] = m_data_stream_tready;
                m_data_stream_tdata  = s_data_stream_tdata[grant_ch*DATA_WIDTH +: DATA_WIDTH];
                m_data_stream_tkeep  = s_data_stream_tkeep[grant_ch*KEEP_WIDTH +: KEEP_WIDTH];
                m_data_stream_tfirst = s_data_stream_tfirst[grant_ch];
                m_data_stream_tlast  = s_data_stream_tlast[grant_ch];
            end
            default: ;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_udp_eth_tx_mux.sv
// Directed bench for udp_eth_tx_mux: per-channel packet sources, downstream sink, scenario tasks.
module tb_udp_eth_tx_mux;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 256;
    localparam int unsigned KW  = 32;
    localparam int unsigned CW  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset_n;
    logic [NCH-1:0]      ch_enable;
    logic [NCH-1:0]      s_udp_meta_valid, s_udp_meta_ready;
    logic [NCH*32-1:0]   s_udp_meta_ip_addr;
    logic [NCH*16-1:0]   s_udp_meta_dst_port, s_udp_meta_src_port, s_udp_meta_data_len;
    logic [NCH-1:0]      s_data_stream_tvalid, s_data_stream_tready;
    logic [NCH*DW-1:0]   s_data_stream_tdata;
    logic [NCH*KW-1:0]   s_data_stream_tkeep;
    logic [NCH-1:0]      s_data_stream_tfirst, s_data_stream_tlast;
    logic                m_udp_meta_valid, m_udp_meta_ready;
    logic [31:0]         m_udp_meta_ip_addr;
    logic [15:0]         m_udp_meta_dst_port, m_udp_meta_src_port, m_udp_meta_data_len;
    logic                m_data_stream_tvalid, m_data_stream_tready;
    logic [DW-1:0]       m_data_stream_tdata;
    logic [KW-1:0]       m_data_stream_tkeep;
    logic                m_data_stream_tfirst, m_data_stream_tlast;
    logic [1:0]          grant_ch;
    logic                busy;
    logic [NCH*CW-1:0]   pkt_cnt;

    udp_eth_tx_mux #(.NUM_CH(NCH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .ch_enable(ch_enable),
        .s_udp_meta_valid(s_udp_meta_valid), .s_udp_meta_ready(s_udp_meta_ready),
        .s_udp_meta_ip_addr(s_udp_meta_ip_addr), .s_udp_meta_dst_port(s_udp_meta_dst_port),
        .s_udp_meta_src_port(s_udp_meta_src_port), .s_udp_meta_data_len(s_udp_meta_data_len),
        .s_data_stream_tvalid(s_data_stream_tvalid), .s_data_stream_tready(s_data_stream_tready),
        .s_data_stream_tdata(s_data_stream_tdata), .s_data_stream_tkeep(s_data_stream_tkeep),
        .s_data_stream_tfirst(s_data_stream_tfirst), .s_data_stream_tlast(s_data_stream_tlast),
        .m_udp_meta_valid(m_udp_meta_valid), .m_udp_meta_ready(m_udp_meta_ready),
        .m_udp_meta_ip_addr(m_udp_meta_ip_addr), .m_udp_meta_dst_port(m_udp_meta_dst_port),
        .m_udp_meta_src_port(m_udp_meta_src_port), .m_udp_meta_data_len(m_udp_meta_data_len),
        .m_data_stream_tvalid(m_data_stream_tvalid), .m_data_stream_tready(m_data_stream_tready),
        .m_data_stream_tdata(m_data_stream_tdata), .m_data_stream_tkeep(m_data_stream_tkeep),
        .m_data_stream_tfirst(m_data_stream_tfirst), .m_data_stream_tlast(m_data_stream_tlast),
        .grant_ch(grant_ch), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    typedef struct {
        int          ch;
        logic [31:0] ip;
        logic [15:0] dst, src, len;
        int          cyc;
    } meta_rec_t;

    typedef struct {
        int          ch;
        logic [31:0] word;
        logic [31:0] keep;
        logic        first, last;
        int          cyc;
    } data_rec_t;

    meta_rec_t meta_log[$];
    data_rec_t data_log[$];

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          src_st[NCH], pkts_left[NCH], beats[NCH], beat_idx[NCH], seq[NCH];
    logic [31:0] cfg_ip[NCH];
    logic [15:0] cfg_dst[NCH], cfg_src[NCH], cfg_len[NCH];
    logic        tready_toggle;
    logic        obs_tvalid, obs_tready;
    logic [31:0] obs_tdata;
    logic [3:0]  ready_seen;
    bit          to;

    // Upstream sources: state 1 = offering meta, 2 = streaming data beats
    task automatic drive_sources();
        for (int i = 0; i < NCH; i++) begin
            s_udp_meta_valid[i]     = (src_st[i] == 1);
            s_data_stream_tvalid[i] = (src_st[i] == 2);
            s_data_stream_tfirst[i] = (beat_idx[i] == 0);
            s_data_stream_tlast[i]  = (beat_idx[i] == beats[i] - 1);
            s_data_stream_tdata[i*DW +: DW] = {8{8'(i), 16'(seq[i]), 8'(beat_idx[i])}};
            s_data_stream_tkeep[i*KW +: KW] = '1;
            s_udp_meta_ip_addr[i*32 +: 32]  = cfg_ip[i];
            s_udp_meta_dst_port[i*16 +: 16] = cfg_dst[i];
            s_udp_meta_src_port[i*16 +: 16] = cfg_src[i];
            s_udp_meta_data_len[i*16 +: 16] = cfg_len[i];
        end
    endtask

    task automatic reset_sources();
        for (int i = 0; i < NCH; i++) begin
            src_st[i] = 0; pkts_left[i] = 0; beats[i] = 1; beat_idx[i] = 0; seq[i] = 0;
            cfg_ip[i] = 32'h0A000000 + 32'(i); cfg_dst[i] = 16'd4791;
            cfg_src[i] = 16'd5000 + 16'(i); cfg_len[i] = 16'd32;
        end
        drive_sources();
    endtask

    task automatic start_src(input int ch, input int n, input int nb);
        pkts_left[ch] = n; beats[ch] = nb; beat_idx[ch] = 0; seq[ch] = 0; src_st[ch] = 1;
        drive_sources();
    endtask

    // One clock: sample settled handshakes at negedge, advance sources after posedge
    task automatic cycle();
        logic [3:0] mh, dh;
        meta_rec_t  mr;
        data_rec_t  dr;
        @(negedge clk);
        mh = s_udp_meta_valid & s_udp_meta_ready;
        dh = s_data_stream_tvalid & s_data_stream_tready;
        obs_tvalid = m_data_stream_tvalid;
        obs_tready = m_data_stream_tready;
        obs_tdata  = m_data_stream_tdata[31:0];
        ready_seen = ready_seen | s_udp_meta_ready | s_data_stream_tready;
        if (m_udp_meta_valid && m_udp_meta_ready) begin
            mr.ch = int'(grant_ch); mr.ip = m_udp_meta_ip_addr; mr.dst = m_udp_meta_dst_port;
            mr.src = m_udp_meta_src_port; mr.len = m_udp_meta_data_len; mr.cyc = cyc;
            meta_log.push_back(mr);
        end
        if (m_data_stream_tvalid && m_data_stream_tready) begin
            dr.ch = int'(grant_ch); dr.word = m_data_stream_tdata[31:0]; dr.keep = m_data_stream_tkeep;
            dr.first = m_data_stream_tfirst; dr.last = m_data_stream_tlast; dr.cyc = cyc;
            data_log.push_back(dr);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NCH; i++) begin
            if (mh[i]) begin
                src_st[i] = 2; beat_idx[i] = 0;
            end else if (dh[i]) begin
                if (beat_idx[i] == beats[i] - 1) begin
                    pkts_left[i]--; seq[i]++; beat_idx[i] = 0;
                    src_st[i] = (pkts_left[i] > 0) ? 1 : 0;
                end else begin
                    beat_idx[i]++;
                end
            end
        end
        drive_sources();
        if (tready_toggle) m_data_stream_tready = ~m_data_stream_tready;
    endtask

    task automatic run_until(input logic [3:0] mask, input int budget, output bit timed_out);
        bit pending;
        timed_out = 1'b1;
        for (int k = 0; k < budget; k++) begin
            cycle();
            pending = 1'b0;
            for (int i = 0; i < NCH; i++) if (mask[i] && pkts_left[i] != 0) pending = 1'b1;
            if (!pending && !busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        reset_sources();
        tready_toggle = 1'b0;
        m_udp_meta_ready = 1'b1;
        m_data_stream_tready = 1'b1;
        ch_enable = '1;
        repeat (2) cycle();
        reset_n = 1'b1;
        repeat (3) cycle();
        meta_log.delete();
        data_log.delete();
        ready_seen = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        reset_sources();
        tready_toggle = 1'b0;
        m_udp_meta_ready = 1'b1;
        m_data_stream_tready = 1'b1;
        ch_enable = '1;
        start_src(0, 1, 1);
        repeat (2) cycle();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b exp 0", busy); end
        vectors++; if (grant_ch !== 2'd0) begin miscompares++; $display("FAIL reset_grant: got %0d exp 0", grant_ch); end
        vectors++; if (pkt_cnt !== '0) begin miscompares++; $display("FAIL reset_pkt_cnt: got %0h exp 0", pkt_cnt); end
        vectors++; if (m_udp_meta_valid !== 1'b0) begin miscompares++; $display("FAIL reset_meta_valid: got %0b exp 0", m_udp_meta_valid); end
        vectors++; if (s_udp_meta_ready !== 4'b0) begin miscompares++; $display("FAIL reset_meta_ready: got %0b exp 0", s_udp_meta_ready); end
        vectors++; if (m_data_stream_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %0b exp 0", m_data_stream_tvalid); end
        vectors++; if (s_data_stream_tready !== 4'b0) begin miscompares++; $display("FAIL reset_tready: got %0b exp 0", s_data_stream_tready); end
        reset_n = 1'b1;
    endtask

    task automatic test_single_channel();
        do_reset();
        cfg_ip[1] = 32'h0A000001; cfg_dst[1] = 16'd4791; cfg_src[1] = 16'd5000; cfg_len[1] = 16'd64;
        start_src(1, 1, 2);
        run_until(4'b0010, 40, to);
        vectors++; if (to) begin miscompares++; $display("FAIL single_timeout: got timeout exp completion"); end
        vectors++; if (meta_log.size() != 1) begin miscompares++; $display("FAIL single_meta_count: got %0d exp 1", meta_log.size()); end
        if (meta_log.size() == 1) begin
            vectors++; if (meta_log[0].ch != 1) begin miscompares++; $display("FAIL single_meta_ch: got %0d exp 1", meta_log[0].ch); end
            vectors++; if (meta_log[0].ip !== 32'h0A000001) begin miscompares++; $display("FAIL single_ip: got %0h exp 0a000001", meta_log[0].ip); end
            vectors++; if (meta_log[0].dst !== 16'd4791) begin miscompares++; $display("FAIL single_dst: got %0d exp 4791", meta_log[0].dst); end
            vectors++; if (meta_log[0].src !== 16'd5000) begin miscompares++; $display("FAIL single_src: got %0d exp 5000", meta_log[0].src); end
            vectors++; if (meta_log[0].len !== 16'd64) begin miscompares++; $display("FAIL single_len: got %0d exp 64", meta_log[0].len); end
        end
        vectors++; if (data_log.size() != 2) begin miscompares++; $display("FAIL single_beat_count: got %0d exp 2", data_log.size()); end
        if (data_log.size() == 2) begin
            vectors++;
            if ({data_log[0].first, data_log[0].last, data_log[0].word} !== {1'b1, 1'b0, 32'h01000000}) begin
                miscompares++; $display("FAIL single_beat0: got %0b%0b_%0h exp 10_01000000", data_log[0].first, data_log[0].last, data_log[0].word);
            end
            vectors++;
            if ({data_log[1].first, data_log[1].last, data_log[1].word} !== {1'b0, 1'b1, 32'h01000001}) begin
                miscompares++; $display("FAIL single_beat1: got %0b%0b_%0h exp 01_01000001", data_log[1].first, data_log[1].last, data_log[1].word);
            end
            vectors++; if (data_log[0].keep !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL single_keep: got %0h exp ffffffff", data_log[0].keep); end
        end
        vectors++; if (pkt_cnt[1*CW +: CW] !== 8'd1) begin miscompares++; $display("FAIL single_pkt_cnt1: got %0d exp 1", pkt_cnt[1*CW +: CW]); end
        vectors++; if (grant_ch !== 2'd1) begin miscompares++; $display("FAIL single_grant: got %0d exp 1", grant_ch); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NCH; i++) start_src(i, 2, 1);
        run_until(4'b1111, 100, to);
        vectors++; if (to) begin miscompares++; $display("FAIL rr_timeout: got timeout exp completion"); end
        vectors++; if (meta_log.size() != 8) begin miscompares++; $display("FAIL rr_meta_count: got %0d exp 8", meta_log.size()); end
        if (meta_log.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                vectors++; if (meta_log[k].ch != k % 4) begin miscompares++; $display("FAIL rr_order[%0d]: got %0d exp %0d", k, meta_log[k].ch, k % 4); end
            end
            for (int k = 1; k < 8; k++) begin
                vectors++;
                if (meta_log[k].cyc - meta_log[k-1].cyc != 3) begin
                    miscompares++; $display("FAIL rr_spacing[%0d]: got %0d exp 3", k, meta_log[k].cyc - meta_log[k-1].cyc);
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            vectors++; if (pkt_cnt[i*CW +: CW] !== 8'd2) begin miscompares++; $display("FAIL rr_pkt_cnt[%0d]: got %0d exp 2", i, pkt_cnt[i*CW +: CW]); end
        end
    endtask

    task automatic test_enable_mask();
        int exp_order[6] = '{0, 1, 3, 0, 1, 3};
        do_reset();
        ch_enable = 4'b1011;
        for (int i = 0; i < NCH; i++) start_src(i, 2, 1);
        run_until(4'b1011, 100, to);
        vectors++; if (to) begin miscompares++; $display("FAIL mask_timeout: got timeout exp completion"); end
        vectors++; if (meta_log.size() != 6) begin miscompares++; $display("FAIL mask_meta_count: got %0d exp 6", meta_log.size()); end
        if (meta_log.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                vectors++; if (meta_log[k].ch != exp_order[k]) begin miscompares++; $display("FAIL mask_order[%0d]: got %0d exp %0d", k, meta_log[k].ch, exp_order[k]); end
            end
        end
        vectors++; if (ready_seen[2] !== 1'b0) begin miscompares++; $display("FAIL mask_ch2_ready: got %0b exp 0", ready_seen[2]); end
        vectors++; if (pkt_cnt[2*CW +: CW] !== 8'd0) begin miscompares++; $display("FAIL mask_pkt_cnt2: got %0d exp 0", pkt_cnt[2*CW +: CW]); end
        vectors++; if (pkt_cnt[3*CW +: CW] !== 8'd2) begin miscompares++; $display("FAIL mask_pkt_cnt3: got %0d exp 2", pkt_cnt[3*CW +: CW]); end
    endtask

    task automatic test_backpressure();
        logic        prev_v, prev_r;
        logic [31:0] prev_d;
        int          stalls, stall_bad;
        bit          pending;
        do_reset();
        start_src(0, 1, 4);
        start_src(1, 1, 1);
        tready_toggle = 1'b1;
        prev_v = 1'b0; prev_r = 1'b0; prev_d = '0; stalls = 0; stall_bad = 0;
        to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            cycle();
            if (prev_v && !prev_r) begin
                stalls++;
                if (!obs_tvalid || obs_tdata !== prev_d) stall_bad++;
            end
            prev_v = obs_tvalid; prev_r = obs_tready; prev_d = obs_tdata;
            pending = (pkts_left[0] != 0) || (pkts_left[1] != 0);
            if (!pending && !busy) begin to = 1'b0; break; end
        end
        tready_toggle = 1'b0;
        m_data_stream_tready = 1'b1;
        vectors++; if (to) begin miscompares++; $display("FAIL bp_timeout: got timeout exp completion"); end
        vectors++; if (data_log.size() != 5) begin miscompares++; $display("FAIL bp_beat_count: got %0d exp 5", data_log.size()); end
        if (data_log.size() == 5) begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if ({data_log[k].last, data_log[k].word} !== {(k == 3), 32'(k)}) begin
                    miscompares++; $display("FAIL bp_beat[%0d]: got %0b_%0h exp %0b_%0h", k, data_log[k].last, data_log[k].word, (k == 3), k);
                end
            end
            vectors++; if (data_log[4].ch != 1) begin miscompares++; $display("FAIL bp_second_ch: got %0d exp 1", data_log[4].ch); end
            if (meta_log.size() == 2) begin
                vectors++;
                if (meta_log[1].cyc <= data_log[3].cyc) begin
                    miscompares++; $display("FAIL bp_regrant_early: got meta cyc %0d exp after %0d", meta_log[1].cyc, data_log[3].cyc);
                end
            end
        end
        vectors++; if (meta_log.size() != 2) begin miscompares++; $display("FAIL bp_meta_count: got %0d exp 2", meta_log.size()); end
        vectors++; if (stalls < 1) begin miscompares++; $display("FAIL bp_no_stall: got %0d stalls exp >=1", stalls); end
        vectors++; if (stall_bad != 0) begin miscompares++; $display("FAIL bp_stall_stable: got %0d unstable stalls exp 0", stall_bad); end
        vectors++; if (pkt_cnt[0 +: CW] !== 8'd1) begin miscompares++; $display("FAIL bp_pkt_cnt0: got %0d exp 1", pkt_cnt[0 +: CW]); end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        start_src(0, 256, 1);
        to = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            cycle();
            if (pkts_left[0] == 1 && !busy) begin to = 1'b0; break; end
        end
        vectors++; if (to) begin miscompares++; $display("FAIL wrap_timeout_255: got timeout exp completion"); end
        vectors++; if (pkt_cnt[0 +: CW] !== 8'd255) begin miscompares++; $display("FAIL wrap_pre: got %0d exp 255", pkt_cnt[0 +: CW]); end
        run_until(4'b0001, 20, to);
        vectors++; if (to) begin miscompares++; $display("FAIL wrap_timeout_last: got timeout exp completion"); end
        vectors++; if (pkt_cnt[0 +: CW] !== 8'd0) begin miscompares++; $display("FAIL wrap_post: got %0d exp 0", pkt_cnt[0 +: CW]); end
        vectors++; if (meta_log.size() != 256) begin miscompares++; $display("FAIL wrap_meta_count: got %0d exp 256", meta_log.size()); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        start_src(1, 1, 1);
        start_src(2, 1, 4);
        to = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (data_log.size() == 2) begin to = 1'b0; break; end
        end
        vectors++; if (to) begin miscompares++; $display("FAIL midrst_timeout: got timeout exp beat 1 of ch2"); end
        vectors++; if (busy !== 1'b1 || grant_ch !== 2'd2) begin miscompares++; $display("FAIL midrst_pre: got busy %0b grant %0d exp 1/2", busy, grant_ch); end
        reset_n = 1'b0;
        #1;
        vectors++; if (m_data_stream_tvalid !== 1'b0) begin miscompares++; $display("FAIL midrst_tvalid: got %0b exp 0", m_data_stream_tvalid); end
        vectors++; if (s_data_stream_tready !== 4'b0) begin miscompares++; $display("FAIL midrst_tready: got %0b exp 0", s_data_stream_tready); end
        vectors++; if (m_data_stream_tdata !== '0) begin miscompares++; $display("FAIL midrst_tdata: got %0h exp 0", m_data_stream_tdata[31:0]); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %0b exp 0", busy); end
        vectors++; if (grant_ch !== 2'd0) begin miscompares++; $display("FAIL midrst_grant: got %0d exp 0", grant_ch); end
        vectors++; if (pkt_cnt !== '0) begin miscompares++; $display("FAIL midrst_pkt_cnt: got %0h exp 0", pkt_cnt); end
        reset_sources();
        start_src(0, 1, 1);
        start_src(2, 1, 1);
        repeat (2) cycle();
        meta_log.delete();
        data_log.delete();
        reset_n = 1'b1;
        run_until(4'b0101, 40, to);
        vectors++; if (to) begin miscompares++; $display("FAIL midrst_restart_timeout: got timeout exp completion"); end
        vectors++; if (meta_log.size() != 2) begin miscompares++; $display("FAIL midrst_meta_count: got %0d exp 2", meta_log.size()); end
        if (meta_log.size() == 2) begin
            vectors++; if (meta_log[0].ch != 0) begin miscompares++; $display("FAIL midrst_first_grant: got %0d exp 0", meta_log[0].ch); end
            vectors++; if (meta_log[1].ch != 2) begin miscompares++; $display("FAIL midrst_second_grant: got %0d exp 2", meta_log[1].ch); end
        end
        vectors++; if (pkt_cnt[2*CW +: CW] !== 8'd1) begin miscompares++; $display("FAIL midrst_pkt_cnt2: got %0d exp 1", pkt_cnt[2*CW +: CW]); end
    endtask

    initial begin
        reset_n = 1'b0;
        ready_seen = '0;
        test_reset();
        test_single_channel();
        test_round_robin();
        test_enable_mask();
        test_backpressure();
        test_counter_wrap();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion exp finish before 1ms");
        $fatal(1);
    end

endmodule

// File: doc/udp_eth_tx_mux.md
Name: udp_eth_tx_mux

Overview:
- N-channel packet-granular arbiter in front of the UDP/Ethernet TX path.
- Each channel supplies one UDP metadata beat plus a data stream (tfirst/tlast/tkeep).
- Round-robin grant per packet; the granted channel's metadata, then its whole data stream, pass to a single downstream UDP TX port.
- Adds a per-channel enable mask and per-channel wrapping sent-packet counters.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_WIDTH, 256, data stream width in bits.
- KEEP_WIDTH, 32, DATA_WIDTH/8.
- IP_ADDR_WIDTH, 32, IP address width.
- UDP_PORT_WIDTH, 16, UDP port width.
- UDP_LEN_WIDTH, 16, UDP length width.
- CNT_WIDTH, 16, per-channel packet counter width.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- ch_enable  in  NUM_CH  channel i eligible for grant when bit i = 1.
- s_udp_meta_valid  in  NUM_CH  per-channel metadata valid.
- s_udp_meta_ready  out  NUM_CH  per-channel metadata ready.
- s_udp_meta_ip_addr  in  NUM_CH*IP_ADDR_WIDTH  channel i at slice i.
- s_udp_meta_dst_port  in  NUM_CH*UDP_PORT_WIDTH  per-channel destination port.
- s_udp_meta_src_port  in  NUM_CH*UDP_PORT_WIDTH  per-channel source port.
- s_udp_meta_data_len  in  NUM_CH*UDP_LEN_WIDTH  per-channel payload length.
- s_data_stream_tvalid  in  NUM_CH  per-channel data valid.
- s_data_stream_tready  out  NUM_CH  per-channel data ready.
- s_data_stream_tdata  in  NUM_CH*DATA_WIDTH  per-channel data.
- s_data_stream_tkeep  in  NUM_CH*KEEP_WIDTH  per-channel byte keep.
- s_data_stream_tfirst  in  NUM_CH  first beat of packet.
- s_data_stream_tlast  in  NUM_CH  last beat of packet.
- m_udp_meta_valid / m_udp_meta_ready  out/in  1  downstream metadata handshake.
- m_udp_meta_ip_addr, m_udp_meta_dst_port, m_udp_meta_src_port, m_udp_meta_data_len  out  per-field widths  muxed metadata.
- m_data_stream_tvalid / m_data_stream_tready  out/in  1  downstream data handshake.
- m_data_stream_tdata, m_data_stream_tkeep, m_data_stream_tfirst, m_data_stream_tlast  out  DATA_WIDTH, KEEP_WIDTH, 1, 1  muxed data.
- grant_ch  out  clog2(NUM_CH)  currently granted channel.
- busy  out  1  high in META or DATA state.
- pkt_cnt  out  NUM_CH*CNT_WIDTH  packets completed per channel.

Behaviour:
- Reset (async assert, sync deassert internally):
  - state=IDLE, rr_ptr=NUM_CH-1, grant_ch=0, pkt_cnt=0.
  - All valid and ready outputs 0, busy=0.
- Handshake rules:
  - Transfer occurs when valid&ready are both high on a clk edge.
  - Outputs to non-granted channels: ready=0.
- FSM IDLE:
  - Request set = ch_enable & s_udp_meta_valid.
  - If non-empty, grant the first requester at index rr_ptr+1, rr_ptr+2, … (mod NUM_CH); register grant_ch; go to META next cycle.
  - This is a 1-cycle arbitration bubble.
  - Data valid alone never requests.
- FSM META:
  - m_udp_meta_* = granted slice (combinational mux of registered grant).
  - m_udp_meta_valid = s_udp_meta_valid[grant_ch].
  - s_udp_meta_ready[grant_ch] = m_udp_meta_ready.
  - On handshake go to DATA.
  - Clearing ch_enable after grant does not revoke it.
- FSM DATA:
  - Zero-latency pass-through.
  - m_data_stream_tvalid = s_data_stream_tvalid[grant_ch].
  - s_data_stream_tready[grant_ch] = m_data_stream_tready.
  - tdata, tkeep, tfirst and tlast are muxed from the granted channel.
  - On handshake with tlast=1: pkt_cnt[grant_ch]++ (wraps at 2^CNT_WIDTH), rr_ptr=grant_ch, go to IDLE.
  - Minimum packet cost is 3 cycles: arbitrate, meta, 1 data beat.
- tfirst/tkeep are passed unchecked; packets are delimited by tlast only.
- Fairness: a channel with continuous requests is granted at least once every NUM_CH packets.
- Downstream backpressure holds state; no data is lost or duplicated.
- Reset mid-packet: packet is abandoned, outputs drop to 0 asynchronously, upstream must restart.
- No combinational path from m_*_ready to any m_*_valid.

Test Plan:
- Single channel: ch1 meta {ip=0x0A000001, dst=4791, src=5000, len=64}, 2 data beats -> one meta beat with the same fields, 2 data beats, tlast on beat 2, pkt_cnt[1]=1, grant_ch=1.
- All 4 channels requesting continuously, 1-beat packets -> grant order 0,1,2,3,0,…; each pkt_cnt=2 after 8 packets; 3 cycles per packet at full ready.
- ch_enable=4'b1011 with all channels requesting -> channel 2 is never granted, its readies stay 0, pkt_cnt[2]=0.
- m_data_stream_tready toggles 1,0,1,0 during a 4-beat packet -> 4 beats delivered in order with stable data while stalled, next grant only after tlast handshake.
- pkt_cnt[0] preset by sending 65535 packets on ch0, then one more -> pkt_cnt[0]=0 (wrap).
- reset_n asserted mid-DATA (beat 2 of 4) -> all outputs 0 within the same cycle; after release, ch0 meta is re-granted from IDLE with rr_ptr=NUM_CH-1.
